// File: rtl/stream_deserializer_pkg.sv
// rtl/stream_deserializer_pkg.sv - shared types and slice-ordering helper for the deserializer
package stream_deserializer_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Element k of a word lands in this slice, depending on the chosen ordering.
  function automatic int unsigned slice_index(int unsigned k, int unsigned num_elem, bit lsb_first);
    return lsb_first ? k : (num_elem - 1 - k);
  endfunction

endpackage

// File: rtl/stream_holding_reg.sv
// rtl/stream_holding_reg.sv - one-entry valid/ready output register with load, hold, drain and clear
module stream_holding_reg
  import stream_deserializer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  out_state_e state;

  // A load while FULL is only issued when the consumer drains the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= OUT_EMPTY;
      data_o <= '0;
    end else if (clear_i) begin
      state <= OUT_EMPTY;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (load_i) begin
            state  <= OUT_FULL;
            data_o <= data_i;
          end
        end
        OUT_FULL: begin
          if (load_i) begin
            data_o <= data_i;
          end else if (ready_i) begin
            state <= OUT_EMPTY;
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  assign valid_o = (state == OUT_FULL);

endmodule

// File: rtl/stream_deserializer.sv
// rtl/stream_deserializer.sv - gathers NUM_ELEM narrow stream beats into one wide output word
module stream_deserializer
  import stream_deserializer_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic [ELEM_WIDTH-1:0]            elem_i,
  input  logic                             elem_valid_i,
  output logic                             elem_ready_o,
  output logic [ELEM_WIDTH*NUM_ELEM-1:0]   word_o,
  output logic                             word_valid_o,
  input  logic                             word_ready_i,
  output logic [$clog2(NUM_ELEM+1)-1:0]    count_o
);

  localparam int COUNT_WIDTH = $clog2(NUM_ELEM + 1);
  localparam int WORD_WIDTH  = ELEM_WIDTH * NUM_ELEM;
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(NUM_ELEM - 1);

  if (NUM_ELEM < 2) begin : g_num_elem_check
    $warning("stream_deserializer: NUM_ELEM should be at least 2");
  end

  logic [COUNT_WIDTH-1:0] count;
  logic [WORD_WIDTH-1:0]  assembly;
  logic [WORD_WIDTH-1:0]  next_assembly;
  logic                   accept;
  logic                   last_beat;

  // Only the final beat needs room in the output register; earlier beats never stall.
  assign elem_ready_o = rst_ni & ~clear_i &
                        ((count < LAST_IDX) | ~word_valid_o | word_ready_i);
  assign accept       = elem_valid_i & elem_ready_o;
  assign last_beat    = (count == LAST_IDX);
  assign count_o      = count;

  always_comb begin
    next_assembly = assembly;
    next_assembly[slice_index(int'(count), NUM_ELEM, LSB_FIRST != 0) * ELEM_WIDTH +: ELEM_WIDTH] = elem_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count    <= '0;
      assembly <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (accept) begin
      assembly <= next_assembly;
      count    <= last_beat ? '0 : count + COUNT_WIDTH'(1);
    end
  end

  stream_holding_reg #(
    .WIDTH(WORD_WIDTH)
  ) u_out_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .load_i (accept & last_beat),
    .data_i (next_assembly),
    .data_o (word_o),
    .valid_o(word_valid_o),
    .ready_i(word_ready_i)
  );

endmodule
